fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a ROM from RESET_PC to LAST_PC into a
// one-entry decode buffer, with stall, redirect, restart and halt handling.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter logic [31:0] LAST_PC  = 32'h20,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        rom_en,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        halted
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] instr_out_next, instr_pc_next;
   logic        instr_valid_next;
   logic        fetch;
   logic        consume;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instr_out   <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         instr_out   <= instr_out_next;
         instr_pc    <= instr_pc_next;
         instr_valid <= instr_valid_next;
      end
   end

   // Priority within RUN: start, then redirect, then fetch, then plain consume.
   always_comb begin
      state_next       = state;
      pc_next          = pc;
      instr_out_next   = instr_out;
      instr_pc_next    = instr_pc;
      instr_valid_next = instr_valid;
      fetch            = 1'b0;
      consume          = instr_valid && instr_ready;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
               pc_next    = RESET_PC;
            end
         end
         RUN: begin
            if (start) begin
               pc_next          = RESET_PC;
               instr_valid_next = 1'b0;
            end else if (redirect) begin
               pc_next          = {redirect_pc[31:2], 2'b00};
               instr_valid_next = 1'b0;
            end else if (!stall && (!instr_valid || instr_ready)) begin
               fetch            = 1'b1;
               instr_out_next   = rom_data;
               instr_pc_next    = pc;
               instr_valid_next = 1'b1;
               pc_next          = pc + PC_STEP;
               if (pc == LAST_PC) state_next = HALT;
            end else if (consume) begin
               instr_valid_next = 1'b0;
            end
         end
         HALT: begin
            if (start) begin
               state_next       = RUN;
               pc_next          = RESET_PC;
               instr_valid_next = 1'b0;
            end else if (consume) begin
               instr_valid_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign rom_en   = fetch;
   assign rom_addr = (state == RUN) ? pc : '0;
   assign halted   = (state == HALT);

endmodule
